watch_countdown_top: RTL

Countdown timer that runs a loaded H:M:S value down to 00:00:00 at one step per second and pulses `o_done` on expiry. It sits beside the up-counting watch block in the watch subsystem and shares its clocking scheme: the second rate is derived from the system clock using the `i_freq` cycles-per-second input. It uses the same `o_sec`/`o_min`/`o_hour` output encoding, so the same display path can show either block.

---
 rtl/watch_countdown_top.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/watch_countdown_top.sv
// H:M:S countdown timer sharing the watch block's prescaler scheme.
// Runs loaded time to 00:00:00 and pulses o_done on expiry.
module watch_countdown_top #(
  parameter int P_COUNT_BIT = 30,
  parameter int P_SEC_BIT   = 6,
  parameter int P_MIN_BIT   = 6,
  parameter int P_HOUR_BIT  = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_run_en,
  input  logic [P_COUNT_BIT-1:0] i_freq,
  input  logic                   i_load,
  input  logic [P_SEC_BIT-1:0]   i_load_sec,
  input  logic [P_MIN_BIT-1:0]   i_load_min,
  input  logic [P_HOUR_BIT-1:0]  i_load_hour,
  input  logic                   i_start,
  input  logic                   i_pause,
  output logic [P_SEC_BIT-1:0]   o_sec,
  output logic [P_MIN_BIT-1:0]   o_min,
  output logic [P_HOUR_BIT-1:0]  o_hour,
  output logic                   o_running,
  output logic                   o_done,
  output logic                   o_load_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam logic [P_SEC_BIT-1:0]   SEC_MAX  = P_SEC_BIT'(59);
  localparam logic [P_MIN_BIT-1:0]   MIN_MAX  = P_MIN_BIT'(59);
  localparam logic [P_HOUR_BIT-1:0]  HOUR_MAX = P_HOUR_BIT'(23);
  localparam logic [P_COUNT_BIT-1:0] CNT_ONE  = P_COUNT_BIT'(1);

  state_t                 state;
  logic [P_COUNT_BIT-1:0] r_div;

  logic                   counting;
  logic                   tick;
  logic                   load_ok;
  logic                   time_zero;
  logic                   at_one;
  logic                   expire;
  logic [P_SEC_BIT-1:0]   dec_sec;
  logic [P_MIN_BIT-1:0]   dec_min;
  logic [P_HOUR_BIT-1:0]  dec_hour;

  // freq of 0 or 1 ticks every enabled cycle; >= tolerates freq shrinking
  assign counting = (state == S_RUN) && i_run_en;
  assign tick = (i_freq <= CNT_ONE) || (r_div >= (i_freq - CNT_ONE));

  assign load_ok = (i_load_sec <= SEC_MAX)
                && (i_load_min <= MIN_MAX)
                && (i_load_hour <= HOUR_MAX);

  assign time_zero = (o_sec == '0) && (o_min == '0) && (o_hour == '0);
  assign at_one = (o_sec == P_SEC_BIT'(1))
               && (o_min == '0)
               && (o_hour == '0);
  assign expire = counting && tick && at_one;

  always_comb begin
    dec_sec  = o_sec - P_SEC_BIT'(1);
    dec_min  = o_min;
    dec_hour = o_hour;
    if (o_sec == '0) begin
      dec_sec = SEC_MAX;
      if (o_min != '0) begin
        dec_min = o_min - P_MIN_BIT'(1);
      end else begin
        dec_min  = MIN_MAX;
        dec_hour = o_hour - P_HOUR_BIT'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      r_div      <= '0;
      o_sec      <= '0;
      o_min      <= '0;
      o_hour     <= '0;
      o_running  <= 1'b0;
      o_done     <= 1'b0;
      o_load_err <= 1'b0;
    end else begin
      o_done     <= 1'b0;
      o_load_err <= 1'b0;

      if (counting) begin
        r_div <= tick ? '0 : r_div + CNT_ONE;
        if (tick) begin
          o_sec  <= dec_sec;
          o_min  <= dec_min;
          o_hour <= dec_hour;
          if (at_one) begin
            state     <= S_IDLE;
            o_running <= 1'b0;
            o_done    <= 1'b1;
          end
        end
      end

      // load never coincides with a tick: it is only accepted outside RUN
      if (i_load) begin
        if ((state != S_RUN) && load_ok) begin
          o_sec  <= i_load_sec;
          o_min  <= i_load_min;
          o_hour <= i_load_hour;
          r_div  <= '0;
        end else begin
          o_load_err <= 1'b1;
        end
      end else if (i_start) begin
        unique case (state)
          S_IDLE: begin
            if (!time_zero) begin
              state     <= S_RUN;
              r_div     <= '0;
              o_running <= 1'b1;
            end
          end
          S_PAUSE: begin
            state     <= S_RUN;
            o_running <= 1'b1;
          end
          default: ;
        endcase
      end else if (i_pause) begin
        if ((state == S_RUN) && !expire) begin
          state     <= S_PAUSE;
          o_running <= 1'b0;
        end
      end
    end
  end

endmodule
